programmable_instruction_memory: RTL and testbench
==================================================

PROGRAMMABLE_INSTRUCTION_MEMORY -- requirements
Module: programmable_instruction_memory

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DATA_W, 16, instruction width.
- ADDR_W, 16, byte-address (PC) width.
- DEPTH, 32, number of instruction words (power of 2, 2..1024).
- HALT_WORD, 16'h0000, encoding treated as HALT.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous, active-high reset.
- from_pc, in, ADDR_W, byte address of requested instruction.
- fetch_req, in, 1, fetch request.
- stall, in, 1, hold current output.
- instruction, out, DATA_W, fetched word.
- instr_valid, out, 1, instruction is valid.
- load_en, in, 1, program-load write strobe.
- load_addr, in, ADDR_W, byte address of the load.
- load_data, in, DATA_W, word to write.
- halted, out, 1, HALT fetched (sticky).
- fault, out, 1, bad fetch address (sticky).
- fault_pc, out, ADDR_W, address that caused the fault.
REQ-003 Reset SHALL be synchronous and active-high on rst; clk is the only clock.

Function
REQ-004 Storage SHALL be DEPTH words of DATA_W; word index = addr[log2(DEPTH):1].
REQ-005 Fetch latency SHALL be 1 cycle: a request accepted at edge N drives instruction/instr_valid after edge N.
REQ-006 A fetch is accepted when fetch_req=1, stall=0, load_en=0, and the state is RUN.
REQ-007 With stall=1, instruction, instr_valid, halted and fault SHALL hold their values.
REQ-008 A cycle with no accepted fetch and stall=0 SHALL drive instr_valid=0, with instruction unchanged.
REQ-009 load_en=1 SHALL write load_data to word load_addr at the edge, in any state, regardless of stall.
- Write priority: a simultaneous fetch is not accepted.
- load_addr[0] is ignored.
- Loads with load_addr >= 2*DEPTH are dropped silently.
REQ-010 A fetch the cycle after a load to the same word SHALL return the new data; there is no bypass within the same cycle, since the fetch is blocked.
REQ-011 Fault checks on an accepted-candidate fetch (fetch_req=1, stall=0, load_en=0, RUN):
- misaligned: from_pc[0]=1.
- out of range: from_pc >= 2*DEPTH.
- On either, the fetch SHALL NOT return data: instr_valid=0, fault=1, fault_pc=from_pc, state goes to FAULT.
REQ-012 The state machine SHALL have three states: RUN (reset state), HALT, FAULT.
- RUN -> HALT when an accepted fetch returns HALT_WORD.
- RUN -> FAULT per REQ-011.
- HALT and FAULT are left only by rst.
REQ-013 The returned HALT_WORD SHALL be presented with instr_valid=1 and halted=1 in the same cycle.
REQ-014 In HALT, instruction SHALL equal HALT_WORD and instr_valid=0 on later cycles; fetches are ignored.
REQ-015 In FAULT, instr_valid=0 and fetches are ignored; loads are still accepted.
REQ-016 If fault and halt conditions coincide, fault SHALL take precedence: a misaligned address never reads memory.

Reset
REQ-017 On rst=1 at an edge, the block SHALL set:
- state=RUN, instruction=HALT_WORD, instr_valid=0, halted=0, fault=0, fault_pc=0.
- every memory word = HALT_WORD.
REQ-018 rst SHALL override load_en, fetch_req and stall in the same cycle; an in-flight fetch result is discarded.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- (a) Load words 0..3 with FE21, FB22, 2388, 149A at addresses 0,2,4,6, then fetch pc=0,2,4,6 on consecutive cycles -> same words, instr_valid=1, one cycle after each request.
- (b) Fetch pc=4 with stall=1 on the following two cycles -> instruction stays 2388, instr_valid stays 1, new from_pc ignored.
- (c) Load 0000 at address 8 and fetch pc=8 -> instruction=0000, instr_valid=1, halted=1; next cycle instr_valid=0; fetch pc=0 is ignored until rst.
- (d) Fetch pc=3 -> fault=1, fault_pc=0003, instr_valid=0. Separately after rst, fetch pc=0040 (DEPTH=32) -> fault=1, fault_pc=0040.
- (e) load_en=1 (addr 2, data F564) with fetch_req=1, pc=2 in the same cycle -> instr_valid=0 next cycle; re-fetching pc=2 -> F564.
- (f) Assert rst mid-stream after (a) -> all outputs return to reset values; fetch pc=0 -> 0000 with halted=1.

Source files
------------

// File: rtl/programmable_instruction_memory.sv
// Programmable instruction memory: single-cycle fetch port, program-load write port,
// sticky HALT/FAULT status with a small RUN/HALT/FAULT controller.
module programmable_instruction_memory #(
  parameter int unsigned         DATA_W    = 16,
  parameter int unsigned         ADDR_W    = 16,
  parameter int unsigned         DEPTH     = 32,
  parameter logic [DATA_W-1:0]   HALT_WORD = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] from_pc,
  input  logic              fetch_req,
  input  logic              stall,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              halted,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_pc
);

  localparam int unsigned       IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(2 * DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_instruction;
  logic              r_instr_valid;
  logic              r_halted;
  logic              r_fault;
  logic [ADDR_W-1:0] r_fault_pc;

  logic             w_load_ok;
  logic [IDX_W-1:0] w_load_idx;
  logic             w_fetch_cand;
  logic             w_misaligned;
  logic             w_out_of_range;
  logic             w_fetch_bad;
  logic [IDX_W-1:0] w_fetch_idx;
  logic [DATA_W-1:0] w_fetch_word;

  // Range checks use the full address so that every address bit participates.
  always_comb begin
    w_load_ok      = ({1'b0, load_addr} < LIMIT);
    w_load_idx     = load_addr[IDX_W:1];
    w_fetch_cand   = fetch_req && !stall && !load_en && (r_state == ST_RUN);
    w_misaligned   = from_pc[0];
    w_out_of_range = ({1'b0, from_pc} >= LIMIT);
    w_fetch_bad    = w_misaligned || w_out_of_range;
    w_fetch_idx    = from_pc[IDX_W:1];
    w_fetch_word   = r_mem[w_fetch_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_instruction <= HALT_WORD;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_pc    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i[IDX_W-1:0]] <= HALT_WORD;
      end
    end else begin
      if (load_en && w_load_ok) begin
        r_mem[w_load_idx] <= load_data;
      end

      if (!stall) begin
        r_instr_valid <= 1'b0;
        // Fault is evaluated first so a bad address never reads memory.
        if (w_fetch_cand) begin
          if (w_fetch_bad) begin
            r_fault    <= 1'b1;
            r_fault_pc <= from_pc;
            r_state    <= ST_FAULT;
          end else begin
            r_instruction <= w_fetch_word;
            r_instr_valid <= 1'b1;
            if (w_fetch_word == HALT_WORD) begin
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end
          end
        end
      end
    end
  end

  assign instruction = r_instruction;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign fault_pc    = r_fault_pc;

endmodule

// File: tb/tb_programmable_instruction_memory.sv
// Scoreboard bench: driver pushes model-predicted outputs, monitor pops and compares each cycle.
module tb_programmable_instruction_memory;

  localparam int          DEPTH = 32;
  localparam logic [15:0] HALTW = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] from_pc = '0;
  logic        fetch_req = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        load_en = 1'b0;
  logic [15:0] load_addr = '0;
  logic [15:0] load_data = '0;
  logic        halted;
  logic        fault;
  logic [15:0] fault_pc;

  programmable_instruction_memory #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .HALT_WORD(HALTW)
  ) dut (
    .clk(clk), .rst(rst), .from_pc(from_pc), .fetch_req(fetch_req), .stall(stall),
    .instruction(instruction), .instr_valid(instr_valid), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .halted(halted), .fault(fault),
    .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic        valid;
    logic        halted;
    logic        fault;
    logic [15:0] fpc;
    int          step;
  } exp_t;

  exp_t q[$];
  int n_pass = 0;
  int n_total = 0;
  int step = 0;

  // Reference model: program memory as a word array, status as two sticky flags.
  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_instr;
  logic        m_valid, m_halted, m_fault;
  logic [15:0] m_fpc;

  task automatic model_step(input logic r, input logic fr, input logic st, input logic le,
                            input logic [15:0] pc, input logic [15:0] la, input logic [15:0] ld);
    int unsigned pcv, lav;
    pcv = pc;
    lav = la;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = HALTW;
      m_instr = HALTW; m_valid = 0; m_halted = 0; m_fault = 0; m_fpc = '0;
    end else begin
      if (le && lav < 2 * DEPTH) m_mem[lav / 2] = ld;
      if (!st) begin
        m_valid = 0;
        if (fr && !le && !m_halted && !m_fault) begin
          if ((pcv % 2) == 1 || pcv >= 2 * DEPTH) begin
            m_fault = 1;
            m_fpc = pc;
          end else begin
            m_instr = m_mem[pcv / 2];
            m_valid = 1;
            if (m_instr == HALTW) m_halted = 1;
          end
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic fr, input logic st, input logic le,
                       input logic [15:0] pc, input logic [15:0] la, input logic [15:0] ld);
    exp_t e;
    @(negedge clk);
    rst = r; fetch_req = fr; stall = st; load_en = le;
    from_pc = pc; load_addr = la; load_data = ld;
    model_step(r, fr, st, le, pc, la, ld);
    step++;
    e.instr = m_instr; e.valid = m_valid; e.halted = m_halted;
    e.fault = m_fault; e.fpc = m_fpc; e.step = step;
    q.push_back(e);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    drive(0, 0, 0, 1, 16'h0, a, d);
  endtask

  task automatic fetch(input logic [15:0] pc);
    drive(0, 1, 0, 0, pc, 16'h0, 16'h0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_total++;
      if (instruction === e.instr && instr_valid === e.valid && halted === e.halted &&
          fault === e.fault && fault_pc === e.fpc) begin
        n_pass++;
      end else begin
        $display("FAIL step%0d outputs: got instr=%h valid=%b halted=%b fault=%b fault_pc=%h, expected instr=%h valid=%b halted=%b fault=%b fault_pc=%h",
                 e.step, instruction, instr_valid, halted, fault, fault_pc,
                 e.instr, e.valid, e.halted, e.fault, e.fpc);
      end
    end
  end

  initial begin
    logic [15:0] pc, la, ld;
    int sel;

    do_reset();
    do_reset();
    idle();

    // (a) program load then back-to-back fetches
    load(16'd0, 16'hFE21);
    load(16'd2, 16'hFB22);
    load(16'd4, 16'h2388);
    load(16'd6, 16'h149A);
    fetch(16'd0);
    fetch(16'd2);
    fetch(16'd4);
    fetch(16'd6);
    // (b) stall holds a valid word while from_pc changes
    fetch(16'd4);
    drive(0, 1, 1, 0, 16'd6, 16'h0, 16'h0);
    drive(0, 1, 1, 0, 16'd0, 16'h0, 16'h0);
    idle();
    // (f) reset mid-stream clears outputs and memory
    fetch(16'd2);
    do_reset();
    fetch(16'd0);
    idle();

    // (c) HALT fetch is sticky
    do_reset();
    load(16'd8, 16'h0000);
    load(16'd0, 16'h1234);
    fetch(16'd8);
    fetch(16'd0);
    fetch(16'd0);
    load(16'd10, 16'hABCD);
    idle();

    // (d) misaligned then out-of-range fault
    do_reset();
    load(16'd2, 16'h5555);
    fetch(16'd3);
    fetch(16'd2);
    idle();
    do_reset();
    fetch(16'h0040);
    fetch(16'h0000);
    idle();

    // (e) load blocks same-cycle fetch; next fetch sees new data
    do_reset();
    drive(0, 1, 0, 1, 16'd2, 16'd2, 16'hF564);
    fetch(16'd2);
    // dropped out-of-range load and ignored load_addr[0]
    load(16'h0041, 16'h7777);
    load(16'd5, 16'h6666);
    fetch(16'd4);
    fetch(16'd0);
    idle();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8) pc = 16'($urandom_range(0, DEPTH - 1) * 2);
      else if (sel == 8) pc = 16'($urandom_range(0, 2 * DEPTH - 1) | 1);
      else pc = 16'($urandom_range(2 * DEPTH, 2 * DEPTH + 40));
      la = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(2 * DEPTH, 200))
                                       : 16'($urandom_range(0, 2 * DEPTH - 1));
      ld = ($urandom_range(0, 7) == 0) ? HALTW : 16'($urandom_range(1, 16'hFFFF));
      drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), pc, la, ld);
    end
    idle();

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expected responses left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
